memtest_sequencer: RTL
======================

// Module: memtest_sequencer
// PURPOSE
//  Run-control for the SDRAM memory tester: selects frequency step and chip, drives the PLL-reconfig
//  handshake, holds the tester in reset while the clock settles, runs an auto frequency sweep, keeps a
//  BCD elapsed-minutes timer plus a fast tick phase for the OSD marker. Sits between user input decode
//  and the tester/PLL-config logic. Generalises the hard-coded 38-step, 3-chip top-level controller.
// PARAMETERS
//  CLK_HZ        50_000_000  clk frequency; sets minute and tick dividers
//  NUM_STEPS     38          frequency-table entries; step 0 = fastest
//  NUM_CHIPS     3           selectable chip configurations (chip wraps NUM_CHIPS-1 -> 0)
//  BCD_DIGITS    4           elapsed-minutes digits
//  TICK_HZ       10          tick_phase increment rate
//  SETTLE_CYC    1_000_000   cycles test_rst stays high after recfg_done
//  PASS_TARGET   4           passcount needed with failcount==0 to declare a step good in auto mode
// PORTS
//  clk          in   1    system clock
//  reset        in   1    synchronous, active-high
//  cmd_up       in   1    1-cycle pulse: step-1 (faster), leaves auto
//  cmd_down     in   1    1-cycle pulse: step+1 (slower), leaves auto
//  cmd_retest   in   1    1-cycle pulse: rerun current step, leaves auto
//  cmd_auto     in   1    1-cycle pulse: step=0, enter auto sweep
//  cmd_chip     in   1    1-cycle pulse: next chip, rerun
//  passcount    in   32   tester pass counter (cleared by test_rst)
//  failcount    in   32   tester fail counter (cleared by test_rst)
//  recfg_done   in   1    1-cycle pulse from PLL config: new frequency applied and locked
//  step         out  SW   SW=$clog2(NUM_STEPS); index into frequency table
//  chip         out  CW   CW=max(1,$clog2(NUM_CHIPS)); chip select
//  auto_mode    out  1    auto sweep active
//  recfg_req    out  1    level; high from RECFG entry until recfg_done
//  test_rst     out  1    tester reset, high in RECFG and SETTLE
//  sweep_done   out  1    auto sweep finished (DONE state)
//  pass_found   out  1    valid with sweep_done: a step met PASS_TARGET
//  best_step    out  SW   fastest passing step of last sweep
//  elapsed_bcd  out  4*BCD_DIGITS  minutes in RUN, BCD
//  tick_phase   out  3    free-running tick count mod 8 in RUN
// BEHAVIOUR
//  Reset: state=RECFG, step=0, chip=0, auto_mode=1, recfg_req=1, test_rst=1, sweep_done=0,
//   pass_found=0, best_step=0, elapsed_bcd=0, tick_phase=0, pending=0.
//  States: RECFG -> (recfg_done) SETTLE -> (SETTLE_CYC-1 cycles counted) RUN;
//   RUN -> RECFG on accepted command or auto advance; RUN -> DONE on auto termination;
//   DONE -> RECFG on any accepted command. DONE keeps test_rst=0, tester keeps running.
//  Command priority same cycle: cmd_auto > cmd_retest > cmd_chip > cmd_up/cmd_down;
//   cmd_up and cmd_down together with nothing else: both ignored.
//  Bounds: cmd_up at step 0 and cmd_down at NUM_STEPS-1 are ignored entirely (no RECFG).
//  Commands in RECFG/SETTLE update step/chip/auto immediately and set pending; recfg_done in RECFG still
//   moves to SETTLE; at SETTLE exit pending=1 clears pending and re-enters RECFG instead of RUN.
//  Auto (RUN, auto_mode=1), evaluated each cycle, registered:
//   failcount!=0 and step<NUM_STEPS-1 -> step+1, RECFG.
//   failcount!=0 and step==NUM_STEPS-1 -> DONE, pass_found=0, auto_mode=0.
//   failcount==0 and passcount>=PASS_TARGET -> DONE, pass_found=1, best_step=step, auto_mode=0.
//   Fail wins if both hold in one cycle. sweep_done/pass_found clear on RECFG entry.
//  Timer: cleared on RECFG entry, counts only in RUN/DONE. Minute divider counts 0..CLK_HZ*60-1
//   (width from 64-bit localparam math); each wrap increments BCD, digit 9 carries; all-9s wraps to 0.
//  Tick divider 0..CLK_HZ/TICK_HZ-1, tick_phase wraps 7->0.
//  recfg_done outside RECFG is ignored. Reset mid-operation returns to reset values next cycle.
// STRUCTURE
//  memtest_pkg: state enum {RECFG,SETTLE,RUN,DONE}, localparams for divider widths, cmd priority fn.
//  Sub-module memtest_bcd_timer (clk, reset, clr, en -> elapsed_bcd, tick_phase), parametrised by
//   CLK_HZ, TICK_HZ, BCD_DIGITS. Sequencer FSM and step/chip registers in this module.
// TESTING (bench uses CLK_HZ=1000, TICK_HZ=100, SETTLE_CYC=16, NUM_STEPS=4, NUM_CHIPS=3)
//  Reset, recfg_done at cycle 5 -> test_rst falls exactly 16 cycles later, state RUN, step=0.
//  Auto: failcount=1 at steps 0,1; step 2 passcount=4, failcount=0 -> sweep_done=1, pass_found=1,
//   best_step=2, auto_mode=0; fail at step 3 in another sweep -> pass_found=0.
//  cmd_up at step 0 -> no recfg_req; cmd_down at 3 -> ignored; cmd_up+cmd_down -> ignored.
//  cmd_chip x3 -> chip 1,2,0; each raises recfg_req next cycle.
//  cmd_down during SETTLE -> step updates, SETTLE exits to RECFG, not RUN.
//  Run 60000 cycles in RUN -> elapsed_bcd=0x0001; preload 9999 min -> wraps to 0x0000;
//   tick_phase steps every 10 cycles, 7->0.

Source files
------------

// File: rtl/memtest_pkg.sv
// Shared types and helpers for the SDRAM memory-tester run-control:
// sequencer states, decoded user commands and counter sizing.
package memtest_pkg;

    typedef enum logic [1:0] {
        ST_RECFG,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_AUTO,
        CMD_RETEST,
        CMD_CHIP,
        CMD_UP,
        CMD_DOWN
    } cmd_t;

    // Bits needed by a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_width(input longint unsigned n);
        return (n <= 64'd2) ? 1 : $clog2(n);
    endfunction

    // Same-cycle arbitration of user commands; up together with down cancels.
    function automatic cmd_t cmd_pick(input logic auto_c, input logic retest_c,
                                      input logic chip_c, input logic up_c,
                                      input logic down_c);
        if (auto_c)             return CMD_AUTO;
        if (retest_c)           return CMD_RETEST;
        if (chip_c)             return CMD_CHIP;
        if (up_c && !down_c)    return CMD_UP;
        if (down_c && !up_c)    return CMD_DOWN;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/memtest_bcd_timer.sv
// Elapsed-minutes BCD counter plus a free-running 3-bit tick phase for the
// on-screen marker; both advance only while en is high and clear on clr.
module memtest_bcd_timer
    import memtest_pkg::*;
#(
    parameter longint unsigned CLK_HZ     = 50_000_000,
    parameter longint unsigned TICK_HZ    = 10,
    parameter int              BCD_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    output logic [4*BCD_DIGITS-1:0] elapsed_bcd,
    output logic [2:0]              tick_phase
);

    localparam longint unsigned MIN_CYC  = CLK_HZ * 64'd60;
    localparam longint unsigned TICK_CYC = CLK_HZ / TICK_HZ;
    localparam int MW = cnt_width(MIN_CYC);
    localparam int TW = cnt_width(TICK_CYC);
    localparam logic [MW-1:0] MIN_LAST  = MW'(MIN_CYC - 64'd1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 64'd1);

    logic [MW-1:0]           min_cnt;
    logic [TW-1:0]           tick_cnt;
    logic [4*BCD_DIGITS-1:0] bcd_q;
    logic [4*BCD_DIGITS-1:0] bcd_inc;
    logic [2:0]              phase_q;
    logic                    carry;

    // Ripple a +1 through the digits; an all-nines value rolls over to zero.
    always_comb begin
        bcd_inc = bcd_q;
        carry   = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (bcd_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            min_cnt  <= '0;
            tick_cnt <= '0;
            bcd_q    <= '0;
            phase_q  <= 3'd0;
        end else if (en) begin
            if (min_cnt == MIN_LAST) begin
                min_cnt <= '0;
                bcd_q   <= bcd_inc;
            end else begin
                min_cnt <= min_cnt + MW'(1);
            end
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                phase_q  <= phase_q + 3'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    assign elapsed_bcd = bcd_q;
    assign tick_phase  = phase_q;

endmodule

// File: rtl/memtest_sequencer.sv
// Run-control for the SDRAM tester: step/chip selection, PLL reconfig
// handshake, post-lock settle hold-off, auto frequency sweep and run timer.
module memtest_sequencer
    import memtest_pkg::*;
#(
    parameter longint unsigned CLK_HZ      = 50_000_000,
    parameter int              NUM_STEPS   = 38,
    parameter int              NUM_CHIPS   = 3,
    parameter int              BCD_DIGITS  = 4,
    parameter longint unsigned TICK_HZ     = 10,
    parameter int              SETTLE_CYC  = 1_000_000,
    parameter int              PASS_TARGET = 4,
    localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_up,
    input  logic                    cmd_down,
    input  logic                    cmd_retest,
    input  logic                    cmd_auto,
    input  logic                    cmd_chip,
    input  logic [31:0]             passcount,
    input  logic [31:0]             failcount,
    input  logic                    recfg_done,
    output logic [SW-1:0]           step,
    output logic [CW-1:0]           chip,
    output logic                    auto_mode,
    output logic                    recfg_req,
    output logic                    test_rst,
    output logic                    sweep_done,
    output logic                    pass_found,
    output logic [SW-1:0]           best_step,
    output logic [4*BCD_DIGITS-1:0] elapsed_bcd,
    output logic [2:0]              tick_phase
);

    localparam int SCW = cnt_width(longint'(SETTLE_CYC));
    localparam logic [SW-1:0]  STEP_LAST   = SW'(NUM_STEPS - 1);
    localparam logic [CW-1:0]  CHIP_LAST   = CW'(NUM_CHIPS - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    state_t         state_q, state_d;
    logic [SW-1:0]  step_q, step_d, best_q, best_d;
    logic [CW-1:0]  chip_q, chip_d;
    logic           auto_q, auto_d;
    logic           pending_q, pending_d;
    logic           found_q, found_d;
    logic [SCW-1:0] settle_q, settle_d;
    cmd_t           cmd;
    logic           cmd_ok;
    logic           fail_seen;
    logic           pass_met;

    assign cmd       = cmd_pick(cmd_auto, cmd_retest, cmd_chip, cmd_up, cmd_down);
    // Moves past either end of the frequency table are dropped outright.
    assign cmd_ok    = (cmd != CMD_NONE)
                     && !(cmd == CMD_UP   && step_q == '0)
                     && !(cmd == CMD_DOWN && step_q == STEP_LAST);
    assign fail_seen = (failcount != 32'd0);
    assign pass_met  = (passcount >= 32'(PASS_TARGET));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RECFG;
            step_q    <= '0;
            chip_q    <= '0;
            auto_q    <= 1'b1;
            pending_q <= 1'b0;
            found_q   <= 1'b0;
            best_q    <= '0;
            settle_q  <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            chip_q    <= chip_d;
            auto_q    <= auto_d;
            pending_q <= pending_d;
            found_q   <= found_d;
            best_q    <= best_d;
            settle_q  <= settle_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        chip_d    = chip_q;
        auto_d    = auto_q;
        pending_d = pending_q;
        found_d   = found_q;
        best_d    = best_q;
        settle_d  = '0;

        if (cmd_ok) begin
            case (cmd)
                CMD_AUTO:   begin step_d = '0; auto_d = 1'b1; end
                CMD_RETEST: auto_d = 1'b0;
                CMD_CHIP:   chip_d = (chip_q == CHIP_LAST) ? '0 : chip_q + CW'(1);
                CMD_UP:     begin step_d = step_q - SW'(1); auto_d = 1'b0; end
                CMD_DOWN:   begin step_d = step_q + SW'(1); auto_d = 1'b0; end
                default:    ;
            endcase
        end

        case (state_q)
            ST_RECFG: begin
                if (cmd_ok)     pending_d = 1'b1;
                if (recfg_done) state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                // A command seen while the PLL was busy forces another reconfig.
                if (settle_q == SETTLE_LAST) begin
                    state_d   = (pending_q || cmd_ok) ? ST_RECFG : ST_RUN;
                    pending_d = 1'b0;
                end else begin
                    settle_d = settle_q + SCW'(1);
                    if (cmd_ok) pending_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (cmd_ok) begin
                    state_d = ST_RECFG;
                end else if (auto_q) begin
                    if (fail_seen) begin
                        if (step_q != STEP_LAST) begin
                            step_d  = step_q + SW'(1);
                            state_d = ST_RECFG;
                        end else begin
                            state_d = ST_DONE;
                            found_d = 1'b0;
                            auto_d  = 1'b0;
                        end
                    end else if (pass_met) begin
                        state_d = ST_DONE;
                        found_d = 1'b1;
                        best_d  = step_q;
                        auto_d  = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                if (cmd_ok) state_d = ST_RECFG;
            end
            default: state_d = ST_RECFG;
        endcase

        if (state_d == ST_RECFG && state_q != ST_RECFG) found_d = 1'b0;
    end

    memtest_bcd_timer #(
        .CLK_HZ     (CLK_HZ),
        .TICK_HZ    (TICK_HZ),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clr         (state_q == ST_RECFG),
        .en          (state_q == ST_RUN || state_q == ST_DONE),
        .elapsed_bcd (elapsed_bcd),
        .tick_phase  (tick_phase)
    );

    assign step       = step_q;
    assign chip       = chip_q;
    assign auto_mode  = auto_q;
    assign recfg_req  = (state_q == ST_RECFG);
    assign test_rst   = (state_q == ST_RECFG) || (state_q == ST_SETTLE);
    assign sweep_done = (state_q == ST_DONE);
    assign pass_found = found_q;
    assign best_step  = best_q;

endmodule
